glitch_filter: RTL and testbench

Digital deglitcher that consumes the hazard-prone output of the upstream combinational glitch circuit (`y = a&b | ~b&c`) and produces a clean, clock-synchronous level. It synchronizes the asynchronous input with two flops and requires the synchronized value to hold for `STABLE_CYCLES` consecutive clocks before the clean output changes. It emits one-cycle edge pulses on accepted transitions. Optionally, it counts rejected glitches.

---
 rtl/glitch_filter.sv | 160 ++++++++++++++++
 tb/tb_glitch_filter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/glitch_filter.sv
// glitch_filter: two-flop synchronizer plus persistence filter for a
// hazard-prone asynchronous level. The clean output changes only after the
// synchronized input has disagreed with it for STABLE_CYCLES consecutive
// clocks, and a one-cycle rise/fall pulse marks each accepted change.
// Optional feature macro: GLITCH_CNT_EN builds the saturating counter of
// rejected transitions and its clr_cnt clear; without it glitch_cnt reads 0.
module glitch_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int unsigned    RUN_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W:0] STABLE_EXT = (RUN_W + 1)'(STABLE_CYCLES);
    localparam logic [RUN_W:0] ONE_EXT    = (RUN_W + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch;
    logic             commit;
    logic             reject;

    // Two-flop synchronizer; the filter only ever looks at s2_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // State register: filter state, run length, clean level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state: count consecutive mismatches, commit on the last one,
    // reject (and return to IDLE) as soon as the input agrees again.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        dout_d   = dout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        commit   = 1'b0;
        reject   = 1'b0;
        mismatch = (s2_q != dout_q);

        unique case (state_q)
            IDLE: begin
                if (mismatch) begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        run_d   = RUN_W'(1);
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (mismatch) begin
                    if (({1'b0, run_q} + ONE_EXT) == STABLE_EXT) begin
                        commit = 1'b1;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else begin
                    reject  = 1'b1;
                    run_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                run_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            dout_d  = s2_q;
            run_d   = '0;
            state_d = IDLE;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end
    end

`ifdef GLITCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Glitch counter next value: clear wins over a same-cycle rejection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (reject && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [1:0] unused_cnt_inputs;
    assign unused_cnt_inputs = {clr_cnt, reject};
`endif

    // Outputs come straight from registers.
    always_comb begin
        dout = dout_q;
        rise = rise_q;
        fall = fall_q;
`ifdef GLITCH_CNT_EN
        glitch_cnt = cnt_q;
`else
        glitch_cnt = '0;
`endif
    end

endmodule

// File: tb/tb_glitch_filter.sv
// Testbench for glitch_filter: three instances (default, narrow counter,
// single-cycle filter with RESET_VAL=1) share one stimulus stream and are
// compared each cycle against a behavioural model through a scoreboard.
module tb_glitch_filter;

`ifdef GLITCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       d0, r0, f0;
    logic [7:0] g0;
    logic       d1, r1, f1;
    logic [1:0] g1;
    logic       d2, r2, f2;
    logic [7:0] g2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    glitch_filter #(.STABLE_CYCLES(4), .CNT_W(8), .RESET_VAL(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .dout(d0), .rise(r0), .fall(f0), .glitch_cnt(g0)
    );

    glitch_filter #(.STABLE_CYCLES(4), .CNT_W(2), .RESET_VAL(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .dout(d1), .rise(r1), .fall(f1), .glitch_cnt(g1)
    );

    glitch_filter #(.STABLE_CYCLES(1), .CNT_W(8), .RESET_VAL(1'b1)) u_one (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .dout(d2), .rise(r2), .fall(f2), .glitch_cnt(g2)
    );

    // Behavioural model: run counts consecutive cycles where s2 != dout.
    typedef struct {
        bit s1, s2, dout, rise, fall;
        int run;
        int gc;
    } mdl_t;

    typedef struct {
        logic [10:0] v0;
        logic [4:0]  v1;
        logic [10:0] v2;
    } exp_t;

    mdl_t m0, m1, m2;
    exp_t sb_q[$];

    function automatic mdl_t mdl_reset(bit rv);
        mdl_t m;
        m.s1 = rv; m.s2 = rv; m.dout = rv;
        m.rise = 1'b0; m.fall = 1'b0;
        m.run = 0; m.gc = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit d, bit clr, int sc, int gmax);
        mdl_t n = m;
        n.s1 = d;
        n.s2 = m.s1;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (m.s2 != m.dout) begin
            if (m.run + 1 >= sc) begin
                n.dout = m.s2;
                n.run  = 0;
                n.rise = m.s2;
                n.fall = !m.s2;
            end else begin
                n.run = m.run + 1;
            end
        end else if (m.run != 0) begin
            n.run = 0;
            if (CNT_EN && n.gc < gmax) n.gc = n.gc + 1;
        end
        if (clr) n.gc = 0;
        return n;
    endfunction

    function automatic logic [10:0] pk8(mdl_t m);
        return {m.dout, m.rise, m.fall, 8'(m.gc)};
    endfunction

    function automatic logic [4:0] pk2(mdl_t m);
        return {m.dout, m.rise, m.fall, 2'(m.gc)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare
    // the DUT outputs just after the edge against the popped expectation.
    task automatic step(input bit d, input bit clr);
        exp_t e;
        din = d;
        clr_cnt = clr;
        if (!rst_n) begin
            m0 = mdl_reset(1'b0);
            m1 = mdl_reset(1'b0);
            m2 = mdl_reset(1'b1);
        end else begin
            m0 = mdl_step(m0, d, clr, 4, 255);
            m1 = mdl_step(m1, d, clr, 4, 3);
            m2 = mdl_step(m2, d, clr, 1, 255);
        end
        e.v0 = pk8(m0);
        e.v1 = pk2(m1);
        e.v2 = pk8(m2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("main", 32'({d0, r0, f0, g0}), 32'(e.v0));
        check("sat",  32'({d1, r1, f1, g1}), 32'(e.v1));
        check("one",  32'({d2, r2, f2, g2}), 32'(e.v2));
    endtask

    task automatic hold(input bit d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0);
    endtask

    initial begin
        m0 = mdl_reset(1'b0);
        m1 = mdl_reset(1'b0);
        m2 = mdl_reset(1'b1);

        // Reset held with din toggling, then release with din low.
        for (int i = 0; i < 6; i++) step(i[0], 1'b0);
        rst_n = 1'b1;
        hold(1'b0, 8);

        // Clean rise and clean fall.
        hold(1'b1, 8);
        hold(1'b0, 8);

        // Short 2-clock pulse, then longest rejectable (3) and shortest
        // accepted (4) pulse widths.
        hold(1'b1, 2); hold(1'b0, 8);
        hold(1'b1, 3); hold(1'b0, 8);
        hold(1'b1, 4); hold(1'b0, 8);

        // Upstream static-1 hazard: steady high with a one-cycle dropout.
        hold(1'b1, 8);
        step(1'b0, 1'b0);
        hold(1'b1, 8);
        hold(1'b0, 8);

        // Five rejections saturate the narrow counter.
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, 2);
            hold(1'b0, 4);
        end
        // Sixth rejection lands on the 5th edge of the pulse; clear there.
        for (int i = 0; i < 8; i++) step((i < 2) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0);

        // Mismatch that returns and re-mismatches restarts from 1.
        hold(1'b1, 3); step(1'b0, 1'b0); hold(1'b1, 8); hold(1'b0, 8);

        // Reset asserted mid-PEND takes effect without a clock edge.
        hold(1'b1, 3);
        rst_n = 1'b0;
        #1;
        m0 = mdl_reset(1'b0);
        m1 = mdl_reset(1'b0);
        m2 = mdl_reset(1'b1);
        check("rst_async_main", 32'({d0, r0, f0, g0}), 32'(pk8(m0)));
        check("rst_async_sat",  32'({d1, r1, f1, g1}), 32'(pk2(m1)));
        check("rst_async_one",  32'({d2, r2, f2, g2}), 32'(pk8(m2)));
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        hold(1'b1, 8);
        hold(1'b0, 8);

        // Random runs of assorted widths with occasional clears.
        for (int s = 0; s < 40; s++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 15) == 0));
        end
        hold(1'b0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
